// File: rtl/estacao_reserva_r_pkg.sv
// estacao_reserva_r_pkg: shared ALU opcodes, tag defaults and the reserved "value present" tag
// Used by the issue unit, the CDB arbiter and the reservation station.
package estacao_reserva_r_pkg;
  localparam int NUM_ENT_DEF = 2;
  localparam int TAG_W_DEF   = 3;
  localparam int DATA_W      = 16;
  localparam int TAG_NONE    = 0;
  typedef enum logic [2:0] {
    ULA_ADD = 3'b000,
    ULA_SUB = 3'b001,
    ULA_SLT = 3'b010,
    ULA_CMP = 3'b011,
    ULA_BP4 = 3'b100,
    ULA_BM4 = 3'b101,
    ULA_R6  = 3'b110,
    ULA_R7  = 3'b111
  } ulaop_e;
endpackage

// File: rtl/estacao_reserva_r_unidade_funcional_R.sv
// unidade_funcional_R: combinational 16-bit R-type functional unit
// Ports: a, b operands; op ALU opcode; y result (slt unsigned, cmp = equality, codes 110/111 give 0).
module unidade_funcional_R
  import estacao_reserva_r_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  ulaop_e            op,
  output logic [DATA_W-1:0] y
);
  assign y = op == ULA_ADD ? a + b :
             op == ULA_SUB ? a - b :
             op == ULA_SLT ? {{(DATA_W-1){1'b0}}, a < b} :
             op == ULA_CMP ? {{(DATA_W-1){1'b0}}, a == b} :
             op == ULA_BP4 ? b + DATA_W'(4) :
             op == ULA_BM4 ? b - DATA_W'(4) : '0;
endmodule

// File: rtl/estacao_reserva_r.sv
// estacao_reserva_r: R-type reservation station with CDB snooping and a one-deep result register
// Ports: Clock/Reset (async, active-high); issue_* issue handshake and operands; cdb_* result
// broadcast snooped by waiting entries; res_valid/res_tag/res_data held result, res_grant accepts it.
module estacao_reserva_r
  import estacao_reserva_r_pkg::*;
#(
  parameter int NUM_ENT = NUM_ENT_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_grant
);
  localparam int IW = NUM_ENT > 1 ? $clog2(NUM_ENT) : 1;
  localparam logic [TAG_W-1:0] TN = TAG_W'(TAG_NONE);
  logic [NUM_ENT-1:0] busy_q, busy_d, rdy;
  logic [2:0]         op_q [NUM_ENT], op_d [NUM_ENT];
  logic [DATA_W-1:0]  vj_q [NUM_ENT], vj_d [NUM_ENT], vk_q [NUM_ENT], vk_d [NUM_ENT];
  logic [TAG_W-1:0]   qj_q [NUM_ENT], qj_d [NUM_ENT], qk_q [NUM_ENT], qk_d [NUM_ENT];
  logic [TAG_W-1:0]   tag_q [NUM_ENT], tag_d [NUM_ENT];
  logic               res_valid_q, res_valid_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic [IW-1:0]      free_idx, disp_idx;
  logic               issue_fire, disp, fwd_j, fwd_k, cdb_hit;
  logic [DATA_W-1:0]  fu_a, fu_b, fu_y;
  logic [2:0]         fu_op;
  assign issue_ready = ~&busy_q;
  assign issue_fire  = issue_valid & issue_ready;
  assign cdb_hit     = cdb_valid & (cdb_tag != TN);
  assign fwd_j       = cdb_hit & (issue_qj == cdb_tag);
  assign fwd_k       = cdb_hit & (issue_qk == cdb_tag);
  // Scan from the top down so the lowest-index candidate is the last (winning) assignment.
  always_comb begin
    rdy      = '0;
    free_idx = '0;
    disp_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      rdy[i]   = busy_q[i] & (qj_q[i] == TN) & (qk_q[i] == TN);
      free_idx = busy_q[i] ? free_idx : IW'(i);
      disp_idx = rdy[i] ? IW'(i) : disp_idx;
    end
  end
  assign disp  = (~res_valid_q | res_grant) & |rdy;
  assign fu_a  = disp ? vj_q[disp_idx] : '0;
  assign fu_b  = disp ? vk_q[disp_idx] : '0;
  assign fu_op = disp ? op_q[disp_idx] : '0;
  unidade_funcional_R u_fu (
    .a  (fu_a),
    .b  (fu_b),
    .op (ulaop_e'(fu_op)),
    .y  (fu_y)
  );
  // The issued entry is always a free one and the dispatched one always busy, so they never collide.
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    tag_d  = tag_q;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (cdb_hit && busy_q[i] && qj_q[i] == cdb_tag) begin
        vj_d[i] = cdb_data;
        qj_d[i] = TN;
      end
      if (cdb_hit && busy_q[i] && qk_q[i] == cdb_tag) begin
        vk_d[i] = cdb_data;
        qk_d[i] = TN;
      end
      if (disp && disp_idx == IW'(i)) busy_d[i] = 1'b0;
      if (issue_fire && free_idx == IW'(i)) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        tag_d[i]  = issue_tag;
        vj_d[i]   = fwd_j ? cdb_data : issue_vj;
        vk_d[i]   = fwd_k ? cdb_data : issue_vk;
        qj_d[i]   = fwd_j ? TN : issue_qj;
        qk_d[i]   = fwd_k ? TN : issue_qk;
      end
    end
  end
  always_comb begin
    res_valid_d = disp | (res_valid_q & ~res_grant);
    res_tag_d   = disp ? tag_q[disp_idx] : res_valid_d ? res_tag_q : '0;
    res_data_d  = disp ? (fu_op[2:1] == 2'b11 ? '0 : fu_y) : res_valid_d ? res_data_q : '0;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q      <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
      for (int i = 0; i < NUM_ENT; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_data  = res_data_q;
endmodule

// File: tb/tb_estacao_reserva_r.sv
// tb_estacao_reserva_r: directed and randomized checks of estacao_reserva_r against a behavioural model
module tb_estacao_reserva_r;
  localparam int N = 2;
  logic        Clock = 0;
  logic        Reset = 1;
  logic        issue_valid = 0, issue_ready;
  logic [2:0]  issue_op = 0;
  logic [15:0] issue_vj = 0, issue_vk = 0;
  logic [2:0]  issue_qj = 0, issue_qk = 0, issue_tag = 0;
  logic        cdb_valid = 0;
  logic [2:0]  cdb_tag = 0;
  logic [15:0] cdb_data = 0;
  logic        res_valid, res_grant = 0;
  logic [2:0]  res_tag;
  logic [15:0] res_data;
  int total = 0, bad = 0;

  estacao_reserva_r #(.NUM_ENT(N), .TAG_W(3)) dut (
    .Clock(Clock), .Reset(Reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_grant(res_grant)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          busy;
    logic [2:0]  op;
    logic [15:0] vj, vk;
    logic [2:0]  qj, qk, tag;
  } ent_t;
  ent_t        m [N];
  bit          m_rv;
  logic [2:0]  m_rt;
  logic [15:0] m_rd;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return (a < b) ? 16'd1 : 16'd0;
      3'd3: return (a == b) ? 16'd1 : 16'd0;
      3'd4: return b + 16'd4;
      3'd5: return b - 16'd4;
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit m_free();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0};
    m_rv = 0;
    m_rt = 0;
    m_rd = 0;
  endtask

  // One clock edge: pick from the pre-edge state, then apply dispatch, snoop and issue.
  task automatic m_step();
    ent_t n [N];
    int d = -1, f = -1;
    n = m;
    for (int i = N - 1; i >= 0; i--) begin
      if (!m[i].busy) f = i;
      if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) d = i;
    end
    if (d >= 0 && (!m_rv || res_grant)) begin
      m_rv = 1;
      m_rt = m[d].tag;
      m_rd = alu(m[d].op, m[d].vj, m[d].vk);
      n[d].busy = 0;
    end else if (m_rv && res_grant) begin
      m_rv = 0;
      m_rt = 0;
      m_rd = 0;
    end
    if (cdb_valid && cdb_tag != 0)
      for (int i = 0; i < N; i++)
        if (m[i].busy) begin
          if (m[i].qj == cdb_tag) begin n[i].vj = cdb_data; n[i].qj = 0; end
          if (m[i].qk == cdb_tag) begin n[i].vk = cdb_data; n[i].qk = 0; end
        end
    if (issue_valid && f >= 0) begin
      n[f].busy = 1;
      n[f].op   = issue_op;
      n[f].tag  = issue_tag;
      n[f].vj   = issue_vj;
      n[f].vk   = issue_vk;
      n[f].qj   = issue_qj;
      n[f].qk   = issue_qk;
      if (cdb_valid && issue_qj != 0 && cdb_tag == issue_qj) begin n[f].vj = cdb_data; n[f].qj = 0; end
      if (cdb_valid && issue_qk != 0 && cdb_tag == issue_qk) begin n[f].vk = cdb_data; n[f].qk = 0; end
    end
    m = n;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge Clock);
    chk("issue_ready", issue_ready, m_free());
    chk("res_valid", res_valid, m_rv);
    chk("res_tag", res_tag, m_rt);
    chk("res_data", res_data, m_rd);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic iss(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                     input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] tag);
    issue_valid = 1;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
    issue_tag   = tag;
  endtask

  task automatic drain();
    res_grant = 1;
    tick();
    res_grant = 0;
  endtask

  initial begin
    tick();
    tick();
    Reset = 0;
    chk("rst_valid", res_valid, 0);
    chk("rst_ready", issue_ready, 1);
    // ready issue: 5 + 7
    iss(3'd0, 16'd5, 16'd7, 0, 0, 3'd3);
    tick();
    issue_valid = 0;
    tick();
    chk("add_valid", res_valid, 1);
    chk("add_tag", res_tag, 3);
    chk("add_data", res_data, 12);
    drain();
    chk("grant_clear", res_valid, 0);
    // wakeup via CDB snoop: 0 - 1
    iss(3'd1, 16'd0, 16'd1, 3'd2, 0, 3'd5);
    tick();
    issue_valid = 0;
    tick();
    chk("wait_valid", res_valid, 0);
    cdb_valid = 1;
    cdb_tag   = 2;
    cdb_data  = 0;
    tick();
    cdb_valid = 0;
    chk("snoop_latency", res_valid, 0);
    tick();
    chk("wake_valid", res_valid, 1);
    chk("wake_data", res_data, 16'hFFFF);
    chk("wake_tag", res_tag, 5);
    drain();
    // forwarding at issue: 3 <u 9
    iss(3'd2, 16'd3, 16'd0, 0, 3'd4, 3'd6);
    cdb_valid = 1;
    cdb_tag   = 4;
    cdb_data  = 9;
    tick();
    issue_valid = 0;
    cdb_valid   = 0;
    tick();
    chk("fwd_valid", res_valid, 1);
    chk("fwd_data", res_data, 1);
    drain();
    // backpressure with a full station
    iss(3'd0, 16'd1, 16'd1, 0, 0, 3'd1);
    tick();
    iss(3'd4, 16'd0, 16'd10, 0, 0, 3'd2);
    tick();
    iss(3'd5, 16'd0, 16'd20, 0, 0, 3'd3);
    tick();
    iss(3'd0, 16'd9, 16'd9, 0, 0, 3'd7);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_tag", res_tag, 1);
      chk("hold_data", res_data, 2);
      chk("hold_full", issue_ready, 0);
    end
    issue_valid = 0;
    res_grant   = 1;
    tick();
    chk("bp1_valid", res_valid, 1);
    chk("bp1_tag", res_tag, 3);
    chk("bp1_data", res_data, 16);
    tick();
    chk("bp2_tag", res_tag, 2);
    chk("bp2_data", res_data, 14);
    tick();
    chk("bp_empty", res_valid, 0);
    res_grant = 0;
    // reset mid-operation
    iss(3'd0, 16'd2, 16'd2, 0, 0, 3'd1);
    tick();
    iss(3'd0, 16'd3, 16'd3, 0, 0, 3'd2);
    tick();
    iss(3'd0, 16'd4, 16'd4, 0, 0, 3'd3);
    tick();
    issue_valid = 0;
    Reset = 1;
    #2;
    chk("mrst_valid", res_valid, 0);
    chk("mrst_tag", res_tag, 0);
    chk("mrst_data", res_data, 0);
    chk("mrst_ready", issue_ready, 1);
    tick();
    Reset = 0;
    res_grant = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_valid", res_valid, 0);
    end
    res_grant = 0;
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      issue_valid = $urandom_range(0, 1);
      issue_op    = 3'($urandom_range(0, 7));
      issue_vj    = 16'($urandom);
      issue_vk    = ($urandom_range(0, 3) == 0) ? issue_vj : 16'($urandom);
      issue_qj    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      issue_qk    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      issue_tag   = 3'($urandom_range(1, 7));
      cdb_valid   = $urandom_range(0, 1);
      cdb_tag     = 3'($urandom_range(0, 7));
      cdb_data    = 16'($urandom);
      res_grant   = $urandom_range(0, 2) != 0;
      Reset       = $urandom_range(0, 149) == 0;
      tick();
    end
    Reset = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
